// File: rtl/flash_line_rd.sv
// ============================================================================
// flash_line_rd
// ----------------------------------------------------------------------------
// Flash-side line-fill engine for the instruction cache. A line request
// (20-bit byte address, low 4 bits ignored) is turned into eight consecutive
// 16-bit reads from an external parallel NOR flash. The engine returns the
// line as four 32-bit words, word 0 first, each marked by a one-cycle
// valid pulse.
//
// The engine drives all flash pin timing. Chip-enable and output-enable stay
// low continuously from the first halfword through the last. Each halfword
// access lasts a configurable number of cycles.
//
// Build option:
//   FLASH_PAGE_MODE_EN  When defined, only the first halfword of a burst
//                       waits WAIT_CYC+1 cycles. The remaining seven
//                       halfwords are in-page accesses and wait PAGE_WAIT+1
//                       cycles each. When undefined, PAGE_WAIT is unused.
//
// Parameters:
//   WAIT_CYC   extra wait cycles per halfword access (0..15)
//   PAGE_WAIT  extra wait cycles per in-page halfword (0..15, page mode only)
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   req         in   line read request (level, sampled only while idle)
//   c_addr      in   [19:0] line byte address, bits [3:0] ignored
//   ack         out  one-cycle pulse, request accepted
//   valid       out  one-cycle pulse per returned 32-bit word
//   data        out  [31:0] returned word, held until the next valid
//   busy        out  high whenever the engine is not idle
//   flash_addr  out  [18:0] halfword address to flash
//   flash_ce_n  out  flash chip enable, active-low
//   flash_oe_n  out  flash output enable, active-low
//   flash_we_n  out  flash write enable, tied high (read-only engine)
//   flash_dq    in   [15:0] flash data bus, sampled synchronously
// ============================================================================
module flash_line_rd #(
    parameter int unsigned WAIT_CYC  = 3,
    parameter int unsigned PAGE_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [19:0] c_addr,
    output logic        ack,
    output logic        valid,
    output logic [31:0] data,
    output logic        busy,
    output logic [18:0] flash_addr,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
    input  logic [15:0] flash_dq
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACC_LO  = 2'd1;
    localparam logic [1:0] S_ACC_HI  = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    // Wait-counter reload values. The counter counts down to zero, so a
    // reload of N makes the access last N+1 cycles. The first halfword of
    // a burst always pays the full random-access wait.
    localparam logic [3:0] FIRST_WAIT = 4'(WAIT_CYC);

`ifdef FLASH_PAGE_MODE_EN
    // The rest of the line lies in the same flash page, so only the
    // shorter in-page wait is needed.
    localparam logic [3:0] NEXT_WAIT = 4'(PAGE_WAIT);
`else
    localparam logic [3:0] NEXT_WAIT = 4'(WAIT_CYC);

    logic [3:0] unused_page_wait;
    assign unused_page_wait = 4'(PAGE_WAIT);
`endif

    // The low nibble of the line address has no effect on the line fetched.
    logic unused_addr_bits;
    assign unused_addr_bits = ^c_addr[3:0];

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]  state_q,    state_d;
    logic [15:0] base_q,     base_d;      // line address (c_addr[19:4])
    logic [1:0]  word_cnt_q, word_cnt_d;  // word within the line, wraps 3->0
    logic [3:0]  wait_q,     wait_d;      // cycles left in current halfword
    logic [15:0] lo_half_q,  lo_half_d;   // low halfword of current word
    logic [31:0] data_q,     data_d;
    logic        valid_q,    valid_d;
    logic        ack_q,      ack_d;
    logic [18:0] addr_q,     addr_d;
    logic        ce_n_q,     ce_n_d;
    logic        oe_n_q,     oe_n_d;

    // Last cycle of the current halfword access.
    logic last_cycle;
    assign last_cycle = (wait_q == 4'd0);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        word_cnt_d = word_cnt_q;
        wait_d     = wait_q;
        lo_half_d  = lo_half_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ack_d      = 1'b0;
        addr_d     = addr_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;

        case (state_q)
            S_IDLE: begin
                word_cnt_d = 2'd0;
                ce_n_d     = 1'b1;
                oe_n_d     = 1'b1;
                if (req) begin
                    base_d  = c_addr[19:4];
                    ack_d   = 1'b1;
                    wait_d  = FIRST_WAIT;
                    // Pins are registered, so the address and strobes for
                    // the first halfword are set up on the accepting edge.
                    addr_d  = {c_addr[19:4], 3'b000};
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                    state_d = S_ACC_LO;
                end
            end

            S_ACC_LO: begin
                if (last_cycle) begin
                    lo_half_d = flash_dq;
                    wait_d    = NEXT_WAIT;
                    addr_d    = {base_q, word_cnt_q, 1'b1};
                    state_d   = S_ACC_HI;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end

            S_ACC_HI: begin
                if (last_cycle) begin
                    // The low halfword comes from the lower flash address.
                    data_d     = {flash_dq, lo_half_q};
                    valid_d    = 1'b1;
                    word_cnt_d = word_cnt_q + 2'd1;
                    if (word_cnt_q == 2'd3) begin
                        // Release the flash on the same edge, so the bus
                        // is idle during the recovery cycle.
                        ce_n_d  = 1'b1;
                        oe_n_d  = 1'b1;
                        state_d = S_RECOVER;
                    end else begin
                        // Strobes stay low. Only the address moves to the
                        // next word, with no gap between halfwords.
                        wait_d  = NEXT_WAIT;
                        addr_d  = {base_q, word_cnt_q + 2'd1, 1'b0};
                        state_d = S_ACC_LO;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end

            S_RECOVER: begin
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            base_q     <= 16'd0;
            word_cnt_q <= 2'd0;
            wait_q     <= 4'd0;
            lo_half_q  <= 16'd0;
            data_q     <= 32'd0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            addr_q     <= 19'd0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            word_cnt_q <= word_cnt_d;
            wait_q     <= wait_d;
            lo_half_q  <= lo_half_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            addr_q     <= addr_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ack        = ack_q;
    assign valid      = valid_q;
    assign data       = data_q;
    // Decoded from the state register so reset drops it immediately.
    assign busy       = (state_q != S_IDLE);
    assign flash_addr = addr_q;
    assign flash_ce_n = ce_n_q;
    assign flash_oe_n = oe_n_q;
    assign flash_we_n = 1'b1;

endmodule

// File: tb/tb_flash_line_rd.sv
// ============================================================================
// tb_flash_line_rd
// ----------------------------------------------------------------------------
// Scoreboard bench for flash_line_rd. Two instances are used:
//   u_dut   WAIT_CYC=3, PAGE_WAIT=1  (basic, masking, busy, reset tests)
//   u_dut0  WAIT_CYC=0, PAGE_WAIT=0  (zero-wait edge case)
// Each flash model returns addr[15:0] ^ 16'hA5A5. Stimulus pushes expected
// acks and words into queues. A monitor per instance pops and compares
// them on the falling clock edge.
// ============================================================================
module tb_flash_line_rd;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_v_t;

    typedef struct {
        int          cyc;
        logic [18:0] addr;
    } exp_a_t;

    logic        clk;
    logic        reset_n;
    int          cyc;
    int          n_cmp;
    int          n_bad;

    // Instance 0: WAIT_CYC = 3
    logic        req;
    logic [19:0] c_addr;
    logic        ack, valid, busy, ce_n, oe_n, we_n;
    logic [31:0] data;
    logic [18:0] flash_addr;
    logic [15:0] dq;

    // Instance 1: WAIT_CYC = 0
    logic        req1;
    logic [19:0] c_addr1;
    logic        ack1, valid1, busy1, ce_n1, oe_n1, we_n1;
    logic [31:0] data1;
    logic [18:0] flash_addr1;
    logic [15:0] dq1;

    exp_v_t vq0[$];
    exp_a_t aq0[$];
    exp_v_t vq1[$];
    exp_a_t aq1[$];

    assign dq  = flash_addr[15:0]  ^ 16'hA5A5;
    assign dq1 = flash_addr1[15:0] ^ 16'hA5A5;

    flash_line_rd #(.WAIT_CYC(3), .PAGE_WAIT(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .req(req), .c_addr(c_addr),
        .ack(ack), .valid(valid), .data(data), .busy(busy),
        .flash_addr(flash_addr), .flash_ce_n(ce_n), .flash_oe_n(oe_n),
        .flash_we_n(we_n), .flash_dq(dq)
    );

    flash_line_rd #(.WAIT_CYC(0), .PAGE_WAIT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .req(req1), .c_addr(c_addr1),
        .ack(ack1), .valid(valid1), .data(data1), .busy(busy1),
        .flash_addr(flash_addr1), .flash_ce_n(ce_n1), .flash_oe_n(oe_n1),
        .flash_we_n(we_n1), .flash_dq(dq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Hand-computed expectations
    // ------------------------------------------------------------------------
    // Cycle offset (from the request cycle) of valid pulse k, WAIT_CYC=3.
    function automatic int voff(input int k);
`ifdef FLASH_PAGE_MODE_EN
        case (k) 0: return 7; 1: return 11; 2: return 15; default: return 19; endcase
`else
        case (k) 0: return 9; 1: return 17; 2: return 25; default: return 33; endcase
`endif
    endfunction

    // Cycle offset of the recovery cycle, WAIT_CYC=3.
    function automatic int rec_off();
`ifdef FLASH_PAGE_MODE_EN
        return 19;
`else
        return 33;
`endif
    endfunction

    // First cycle offset of halfword h within a burst, WAIT_CYC=3.
    function automatic int hw_start(input int h);
`ifdef FLASH_PAGE_MODE_EN
        case (h)
            0: return 1;  1: return 5;  2: return 7;  3: return 9;
            4: return 11; 5: return 13; 6: return 15; default: return 17;
        endcase
`else
        case (h)
            0: return 1;  1: return 5;  2: return 9;  3: return 13;
            4: return 17; 5: return 21; 6: return 25; default: return 29;
        endcase
`endif
    endfunction

    // Returned words. sel 0: c_addr 01230, 1: FFFFF, 2: 00040.
    function automatic logic [31:0] word_tbl(input int sel, input int k);
        case (sel * 4 + k)
            0:  return 32'hACBC_ACBD;
            1:  return 32'hACBE_ACBF;
            2:  return 32'hACB8_ACB9;
            3:  return 32'hACBA_ACBB;
            4:  return 32'h5A5C_5A5D;
            5:  return 32'h5A5E_5A5F;
            6:  return 32'h5A58_5A59;
            7:  return 32'h5A5A_5A5B;
            8:  return 32'hA584_A585;
            9:  return 32'hA586_A587;
            10: return 32'hA580_A581;
            default: return 32'hA582_A583;
        endcase
    endfunction

    // Push the expected ack and four words for a request sampled at the end
    // of cycle t0.
    task automatic push_burst(input int dut, input int t0, input int sel,
                              input logic [18:0] first_addr);
        exp_a_t a;
        exp_v_t v;
        a.cyc  = t0 + 1;
        a.addr = first_addr;
        if (dut == 0) aq0.push_back(a); else aq1.push_back(a);
        for (int k = 0; k < 4; k++) begin
            v.data = word_tbl(sel, k);
            if (dut == 0) begin
                v.cyc = t0 + voff(k);
                vq0.push_back(v);
            end else begin
                v.cyc = t0 + 3 + 2 * k;
                vq1.push_back(v);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    // Bounded wait until an instance is idle with its queues drained.
    task automatic wait_idle(input int dut);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (dut == 0)
                done = (vq0.size() == 0) && (aq0.size() == 0) && !busy;
            else
                done = (vq1.size() == 0) && (aq1.size() == 0) && !busy1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL idle_timeout dut%0d: got busy after %0d cycles want idle", dut, n);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        exp_v_t v;
        exp_a_t a;
        while (vq0.size() > 0 && vq0[0].cyc < cyc) begin
            v = vq0.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL dut0_valid_missing: got none want cyc %0d data %h", v.cyc, v.data);
        end
        while (aq0.size() > 0 && aq0[0].cyc < cyc) begin
            a = aq0.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL dut0_ack_missing: got none want cyc %0d", a.cyc);
        end
        if (valid === 1'b1) begin
            if (vq0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut0_valid_unexpected @cyc %0d: got data %h want no valid", cyc, data);
            end else begin
                v = vq0.pop_front();
                chk("dut0_valid_cycle", cyc, v.cyc);
                chk("dut0_data", data, v.data);
                $display("dut0 word cyc=%0d data=%h", cyc, data);
            end
        end
        if (ack === 1'b1) begin
            if (aq0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut0_ack_unexpected @cyc %0d: got ack want none", cyc);
            end else begin
                a = aq0.pop_front();
                chk("dut0_ack_cycle", cyc, a.cyc);
                chk("dut0_ack_addr", {13'd0, flash_addr}, {13'd0, a.addr});
                $display("dut0 ack cyc=%0d addr=%h", cyc, flash_addr);
            end
        end
    end

    always @(negedge clk) begin
        exp_v_t v;
        exp_a_t a;
        while (vq1.size() > 0 && vq1[0].cyc < cyc) begin
            v = vq1.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL dut1_valid_missing: got none want cyc %0d data %h", v.cyc, v.data);
        end
        while (aq1.size() > 0 && aq1[0].cyc < cyc) begin
            a = aq1.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL dut1_ack_missing: got none want cyc %0d", a.cyc);
        end
        if (valid1 === 1'b1) begin
            if (vq1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut1_valid_unexpected @cyc %0d: got data %h want no valid", cyc, data1);
            end else begin
                v = vq1.pop_front();
                chk("dut1_valid_cycle", cyc, v.cyc);
                chk("dut1_data", data1, v.data);
                $display("dut1 word cyc=%0d data=%h", cyc, data1);
            end
        end
        if (ack1 === 1'b1) begin
            if (aq1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut1_ack_unexpected @cyc %0d: got ack want none", cyc);
            end else begin
                a = aq1.pop_front();
                chk("dut1_ack_cycle", cyc, a.cyc);
                chk("dut1_ack_addr", {13'd0, flash_addr1}, {13'd0, a.addr});
                $display("dut1 ack cyc=%0d addr=%h", cyc, flash_addr1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int t0;
        int h;
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        req     = 1'b0;
        c_addr  = 20'd0;
        req1    = 1'b0;
        c_addr1 = 20'd0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ack",        {31'd0, ack},        32'd0);
        chk("rst_valid",      {31'd0, valid},      32'd0);
        chk("rst_data",       data,                32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_flash_addr", {13'd0, flash_addr}, 32'd0);
        chk("rst_ce_n",       {31'd0, ce_n},       32'd1);
        chk("rst_oe_n",       {31'd0, oe_n},       32'd1);
        chk("rst_we_n",       {31'd0, we_n},       32'd1);
        chk("rst1_busy",      {31'd0, busy1},      32'd0);
        chk("rst1_ce_n",      {31'd0, ce_n1},      32'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic line read with a cycle-by-cycle pin walk
        t0 = cyc;
        req = 1'b1;
        c_addr = 20'h01230;
        push_burst(0, t0, 0, 19'h00918);
        for (int c = 1; c <= rec_off() + 1; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (c <= rec_off() - 1) begin
                h = 0;
                for (int j = 1; j < 8; j++) if (c >= hw_start(j)) h = j;
                chk("basic_flash_addr", {13'd0, flash_addr}, 32'h00918 + h);
                chk("basic_ce_n", {31'd0, ce_n}, 32'd0);
                chk("basic_oe_n", {31'd0, oe_n}, 32'd0);
                chk("basic_busy", {31'd0, busy}, 32'd1);
            end else if (c == rec_off()) begin
                chk("recover_ce_n", {31'd0, ce_n}, 32'd1);
                chk("recover_oe_n", {31'd0, oe_n}, 32'd1);
                chk("recover_busy", {31'd0, busy}, 32'd1);
            end else begin
                chk("idle_busy", {31'd0, busy}, 32'd0);
                chk("idle_ce_n", {31'd0, ce_n}, 32'd1);
            end
        end
        wait_idle(0);

        // Low-bit masking at the top of the address space
        t0 = cyc;
        req = 1'b1;
        c_addr = 20'hFFFFF;
        push_burst(0, t0, 1, 19'h7FFF8);
        @(negedge clk);
        req = 1'b0;
        wait_idle(0);

        // Request held through the burst, address changed mid-burst
        t0 = cyc;
        req = 1'b1;
        c_addr = 20'h01230;
        push_burst(0, t0, 0, 19'h00918);
        push_burst(0, t0 + rec_off() + 1, 2, 19'h00020);
        repeat (5) @(negedge clk);
        c_addr = 20'h00040;
        repeat (rec_off() + 2 - 5) @(negedge clk);
        req = 1'b0;
        wait_idle(0);

        // Reset in the middle of a burst
        t0 = cyc;
        req = 1'b1;
        c_addr = 20'h01230;
        push_burst(0, t0, 0, 19'h00918);
        @(negedge clk);
        req = 1'b0;
        repeat (11) @(negedge clk);
        #1;
        reset_n = 1'b0;
        vq0.delete();
        aq0.delete();
        #1;
        chk("midrst_ce_n",  {31'd0, ce_n},  32'd1);
        chk("midrst_oe_n",  {31'd0, oe_n},  32'd1);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_busy",  {31'd0, busy},  32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        t0 = cyc;
        req = 1'b1;
        c_addr = 20'h01230;
        push_burst(0, t0, 0, 19'h00918);
        @(negedge clk);
        req = 1'b0;
        wait_idle(0);

        // Zero wait states on the second instance
        t0 = cyc;
        req1 = 1'b1;
        c_addr1 = 20'h01230;
        push_burst(1, t0, 0, 19'h00918);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req1 = 1'b0;
            if (c <= 8) begin
                chk("w0_flash_addr", {13'd0, flash_addr1}, 32'h00918 + (c - 1));
                chk("w0_ce_n", {31'd0, ce_n1}, 32'd0);
            end else if (c == 9) begin
                chk("w0_recover_ce_n", {31'd0, ce_n1}, 32'd1);
                chk("w0_recover_busy", {31'd0, busy1}, 32'd1);
            end else begin
                chk("w0_idle_busy", {31'd0, busy1}, 32'd0);
            end
        end
        wait_idle(1);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (vq0.size() + aq0.size() + vq1.size() + aq1.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expectations: got %0d pending want 0",
                     vq0.size() + aq0.size() + vq1.size() + aq1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
